// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter and instruction-fetch stage. It holds the PC, fetches one
//   instruction word through the memory controller and presents it to the
//   decoder. It then waits for the ALU to retire that instruction, applies the
//   ALU's PC command and fetches again. Only one instruction is in flight.
//
// Ports
//   Clk          in   system clock, all logic on the rising edge
//   nReset       in   synchronous active-low reset
//   FetchReq     out  fetch request to the memory controller
//   FetchAddr    out  fetch address, always equal to PC
//   MemData      in   instruction word from memory
//   ValidMemData in   MemData valid this cycle (used only while fetching)
//   InstrOut     out  buffered instruction to the decoder
//   InstrPC      out  address InstrOut was fetched from
//   InstrValid   out  InstrOut valid for the decoder
//   InstrReady   in   decoder accepts InstrOut (used only while issuing)
//   ExecDone     in   ALU strobe, MenagePC/PCSet valid (used only in EXEC)
//   MenagePC     in   000 NOP, 001 inc, 010 dec, 011 set, 100 add, else illegal
//   PCSet        in   target address (set) or signed offset (add)
//   PC           out  current program counter
//   Fault        out  illegal MenagePC code seen; sticky until reset
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
   parameter int                ADDR_W       = 32,
   parameter int                INSTR_W      = 32,
   parameter int                STEP         = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
   input  logic               Clk,
   input  logic               nReset,
   output logic               FetchReq,
   output logic [ADDR_W-1:0]  FetchAddr,
   input  logic [INSTR_W-1:0] MemData,
   input  logic               ValidMemData,
   output logic [INSTR_W-1:0] InstrOut,
   output logic [ADDR_W-1:0]  InstrPC,
   output logic               InstrValid,
   input  logic               InstrReady,
   input  logic               ExecDone,
   input  logic [2:0]         MenagePC,
   input  logic [ADDR_W-1:0]  PCSet,
   output logic [ADDR_W-1:0]  PC,
   output logic               Fault
);

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_EXEC  = 3'd3,
      S_FAULT = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

   state_t              r_state;
   state_t              w_next;
   logic [ADDR_W-1:0]   r_pc;
   logic [ADDR_W-1:0]   w_pc_next;
   logic [INSTR_W-1:0]  r_instr;
   logic [ADDR_W-1:0]   r_instr_pc;
   logic                w_capture;

   // State, PC and instruction buffer
   always_ff @(posedge Clk) begin
      if (!nReset) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_VECTOR;
         r_instr    <= '0;
         r_instr_pc <= '0;
      end else begin
         r_state <= w_next;
         r_pc    <= w_pc_next;
         if (w_capture) begin
            r_instr    <= MemData;
            r_instr_pc <= r_pc;
         end
      end
   end

   // Next state and PC update. Inputs are only looked at in the state that
   // owns them, so strobes arriving elsewhere fall through the defaults.
   always_comb begin
      w_next    = r_state;
      w_pc_next = r_pc;
      w_capture = 1'b0;
      case (r_state)
         S_BOOT:  w_next = S_FETCH;
         S_FETCH: begin
            if (ValidMemData) begin
               w_capture = 1'b1;
               w_next    = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (InstrReady) w_next = S_EXEC;
         end
         S_EXEC: begin
            if (ExecDone) begin
               case (MenagePC)
                  3'b000: w_next = S_EXEC;  // multi-cycle ALU op, keep waiting
                  3'b001: begin w_pc_next = r_pc + STEP_V; w_next = S_FETCH; end
                  3'b010: begin w_pc_next = r_pc - STEP_V; w_next = S_FETCH; end
                  3'b011: begin w_pc_next = PCSet;         w_next = S_FETCH; end
                  // two's-complement add: signed offset wraps modulo 2^ADDR_W
                  3'b100: begin w_pc_next = r_pc + PCSet;  w_next = S_FETCH; end
                  default: w_next = S_FAULT;
               endcase
            end
         end
         S_FAULT: w_next = S_FAULT;
         default: w_next = S_BOOT;
      endcase
   end

   // All control outputs come straight from the state register.
   assign FetchReq   = (r_state == S_FETCH);
   assign InstrValid = (r_state == S_ISSUE);
   assign Fault      = (r_state == S_FAULT);
   assign FetchAddr  = r_pc;
   assign PC         = r_pc;
   assign InstrOut   = r_instr;
   assign InstrPC    = r_instr_pc;

endmodule
